// File: rtl/pipe_stage_pkg.sv
// Shared constants for the decode -> execute/writeback stage register.
// Occupancy encodings double as the stage FSM state (derived from the slot valid bits).
package pipe_stage_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int CTRL_ADRMUX = 0;
  localparam int CTRL_WRITE  = 1;
  localparam int CTRL_PCLOAD = 2;

endpackage

// File: rtl/pipe_slot_reg.sv
// One storage slot of the skid stage: {valid, write address, payload, control}.
// clr_valid beats load so a flush always squashes, even when a load is requested.
module pipe_slot_reg #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic              valid_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] data_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clr_valid) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Decode -> execute/writeback stage register built as a 2-entry skid buffer.
// The main slot drives the outputs; the skid slot catches one entry under backpressure.
module pipe_stage_skid_reg
  import pipe_stage_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 16,
  parameter int CTRL_W    = 3,
  parameter bit MASK_CTRL = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              VALID_IN,
  output logic              READY_OUT,
  input  logic [ADDR_W-1:0] writeAd_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [CTRL_W-1:0] CTRL_IN,
  output logic              VALID_OUT,
  input  logic              READY_IN,
  output logic [ADDR_W-1:0] writeAd_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [CTRL_W-1:0] CTRL_OUT,
  output logic [1:0]        COUNT
);

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // READY_OUT depends only on registered state, so no READY_IN -> READY_OUT path exists.
  logic              main_valid, skid_valid;
  logic [ADDR_W-1:0] main_addr, skid_addr;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic              push, pop;
  logic [1:0]        occ;
  logic              main_load, main_from_skid, main_clr;
  logic              skid_load, skid_clr;
  logic [ADDR_W-1:0] main_addr_d;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  assign READY_OUT = !skid_valid;
  assign VALID_OUT = main_valid;
  assign push      = VALID_IN & READY_OUT;
  assign pop       = VALID_OUT & READY_IN;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};
  assign COUNT     = occ;

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (FLUSH) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: main_load = push;
        OCC_ONE: begin
          if (push && pop)  main_load = 1'b1;
          else if (push)    skid_load = 1'b1;
          else if (pop)     main_clr  = 1'b1;
        end
        OCC_TWO: begin
          // Refill main from skid so the older entry always leaves first.
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_addr_d = main_from_skid ? skid_addr : writeAd_IN;
  assign main_data_d = main_from_skid ? skid_data : DATA_IN;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : CTRL_IN;

  pipe_slot_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (main_load),
    .clr_valid (main_clr),
    .addr_d    (main_addr_d),
    .data_d    (main_data_d),
    .ctrl_d    (main_ctrl_d),
    .valid_q   (main_valid),
    .addr_q    (main_addr),
    .data_q    (main_data),
    .ctrl_q    (main_ctrl)
  );

  pipe_slot_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (skid_load),
    .clr_valid (skid_clr),
    .addr_d    (writeAd_IN),
    .data_d    (DATA_IN),
    .ctrl_d    (CTRL_IN),
    .valid_q   (skid_valid),
    .addr_q    (skid_addr),
    .data_q    (skid_data),
    .ctrl_q    (skid_ctrl)
  );

  assign writeAd_OUT = main_addr;
  assign DATA_OUT    = main_data;
  // Bubbles present zero control so they never write the register file or load the PC.
  assign CTRL_OUT    = (MASK_CTRL && !main_valid) ? '0 : main_ctrl;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: scoreboard queue models the 2-entry FIFO occupancy.
// A second instance with MASK_CTRL=0 shares all inputs to observe raw control bits.
module tb_pipe_stage_skid_reg;
  import pipe_stage_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int CTRL_W = 3;
  localparam int W      = ADDR_W + DATA_W + CTRL_W;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RST_N = 1'b0;
  logic              FLUSH = 1'b0;
  logic              VALID_IN = 1'b0;
  logic              READY_IN = 1'b0;
  logic [ADDR_W-1:0] writeAd_IN = '0;
  logic [DATA_W-1:0] DATA_IN = '0;
  logic [CTRL_W-1:0] CTRL_IN = '0;

  logic              ready_out, valid_out, raw_ready, raw_valid;
  logic [ADDR_W-1:0] addr_out, raw_addr;
  logic [DATA_W-1:0] data_out, raw_data;
  logic [CTRL_W-1:0] ctrl_out, raw_ctrl;
  logic [1:0]        count, raw_count;

  pipe_stage_skid_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .MASK_CTRL(1'b1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .VALID_IN(VALID_IN), .READY_OUT(ready_out),
    .writeAd_IN(writeAd_IN), .DATA_IN(DATA_IN), .CTRL_IN(CTRL_IN), .VALID_OUT(valid_out),
    .READY_IN(READY_IN), .writeAd_OUT(addr_out), .DATA_OUT(data_out), .CTRL_OUT(ctrl_out),
    .COUNT(count)
  );

  pipe_stage_skid_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .MASK_CTRL(1'b0)) u_raw (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .VALID_IN(VALID_IN), .READY_OUT(raw_ready),
    .writeAd_IN(writeAd_IN), .DATA_IN(DATA_IN), .CTRL_IN(CTRL_IN), .VALID_OUT(raw_valid),
    .READY_IN(READY_IN), .writeAd_OUT(raw_addr), .DATA_OUT(raw_data), .CTRL_OUT(raw_ctrl),
    .COUNT(raw_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // {VALID_OUT, COUNT, READY_OUT} implied by the model occupancy
  function automatic logic [3:0] exp_status();
    int n = exp_q.size();
    return {n > 0, 2'(n), n < 2};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge, updates the model at the rising edge,
  // and returns at the next falling edge where outputs are stable.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic rdy, input logic fl,
                       input logic rn, output logic accepted);
    logic do_pop;
    VALID_IN = v; writeAd_IN = a; DATA_IN = d; CTRL_IN = c;
    READY_IN = rdy; FLUSH = fl; RST_N = rn;
    accepted = rn && !fl && v && (exp_q.size() < 2);
    do_pop   = rn && !fl && (exp_q.size() > 0) && rdy;
    @(posedge CLK);
    if (!rn || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (accepted) exp_q.push_back({a, d, c});
    end
    @(negedge CLK);
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    drive(1'b0, '0, '0, '0, rdy, 1'b0, 1'b1, acc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic acc;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd7, 16'hFFFF, 3'b111, 1'b1, 1'b0, 1'b0, acc);
      checks++;
      if ({valid_out, count, ready_out, ctrl_out, addr_out, data_out} !==
          {1'b0, 2'd0, 1'b1, 3'b000, 3'd0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got v=%b cnt=%0d rdy=%b ctrl=%b a=%0d d=%h want v=0 cnt=0 rdy=1 ctrl=000 a=0 d=0000",
                 i, valid_out, count, ready_out, ctrl_out, addr_out, data_out);
      end
    end
    idle(1'b1);
    checks++;
    if ({valid_out, count, ready_out} !== exp_status()) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", {valid_out, count, ready_out}, exp_status());
    end
  endtask

  task automatic test_streaming();
    logic acc;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, ADDR_W'(i), DATA_W'(16'h0011 * i), 3'b011, 1'b1, 1'b0, 1'b1, acc);
      checks++;
      if ({valid_out, count, ready_out} !== exp_status() || count > 2'd1) begin
        errors++;
        $display("FAIL stream_status %0d: got %b want %b", i, {valid_out, count, ready_out}, exp_status());
      end
      checks++;
      if (exp_q.size() == 0 || {addr_out, data_out, ctrl_out} !== exp_q[0]) begin
        errors++;
        $display("FAIL stream_head %0d: got %h want %h", i, {addr_out, data_out, ctrl_out},
                 exp_q.size() ? exp_q[0] : '0);
      end
    end
    idle(1'b1);
    checks++;
    if ({valid_out, count, ready_out, ctrl_out} !== {exp_status(), 3'b000}) begin
      errors++;
      $display("FAIL stream_drain: got %b want %b", {valid_out, count, ready_out, ctrl_out}, {exp_status(), 3'b000});
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    drive(1'b1, 3'd5, 16'h0055, 3'b010, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3'd6, 16'h0066, 3'b001, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if ({count, ready_out} !== 3'b10_0 || {valid_out, count, ready_out} !== exp_status()) begin
      errors++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b want cnt=2 rdy=0", count, ready_out);
    end
    checks++;
    if ({addr_out, data_out, ctrl_out} !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_head_first: got %h want %h", {addr_out, data_out, ctrl_out}, exp_q[0]);
    end
    idle(1'b1);
    checks++;
    if ({valid_out, count, ready_out} !== exp_status() || ready_out !== 1'b1 || addr_out !== 3'd6) begin
      errors++;
      $display("FAIL bp_after_pop: got v=%b cnt=%0d rdy=%b a=%0d want v=1 cnt=1 rdy=1 a=6",
               valid_out, count, ready_out, addr_out);
    end
    checks++;
    if ({addr_out, data_out, ctrl_out} !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_head_second: got %h want %h", {addr_out, data_out, ctrl_out}, exp_q[0]);
    end
    idle(1'b1);
    checks++;
    if ({valid_out, count, ready_out} !== exp_status()) begin
      errors++;
      $display("FAIL bp_empty: got %b want %b", {valid_out, count, ready_out}, exp_status());
    end
  endtask

  task automatic test_flush();
    logic acc;
    drive(1'b1, 3'd1, 16'h0101, 3'b111, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3'd2, 16'h0202, 3'b111, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3'd7, 16'h0777, 3'b111, 1'b1, 1'b1, 1'b1, acc);
    checks++;
    if ({valid_out, count, ready_out, ctrl_out} !== {1'b0, 2'd0, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL flush_clear: got v=%b cnt=%0d rdy=%b ctrl=%b want v=0 cnt=0 rdy=1 ctrl=000",
               valid_out, count, ready_out, ctrl_out);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++;
      if (valid_out !== 1'b0 || count !== 2'd0) begin
        errors++;
        $display("FAIL flush_no_ghost %0d: got v=%b cnt=%0d a=%0d want v=0 cnt=0", i, valid_out, count, addr_out);
      end
    end
  endtask

  task automatic test_bubble_mask();
    logic acc;
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_WRITE]  = 1'b1;
    c[CTRL_PCLOAD] = 1'b1;
    drive(1'b1, 3'd3, 16'hBEEF, c, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (ctrl_out !== 3'b110 || raw_ctrl !== 3'b110) begin
      errors++;
      $display("FAIL bubble_valid: got mask=%b raw=%b want 110 110", ctrl_out, raw_ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      checks++;
      if (valid_out !== 1'b0 || ctrl_out !== 3'b000 || raw_valid !== 1'b0 || raw_ctrl !== 3'b110) begin
        errors++;
        $display("FAIL bubble_idle %0d: got v=%b mask=%b raw_v=%b raw=%b want v=0 mask=000 raw_v=0 raw=110",
                 i, valid_out, ctrl_out, raw_valid, raw_ctrl);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    drive(1'b1, 3'd4, 16'h1234, 3'b101, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3'd5, 16'h5678, 3'b011, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (count !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_fill: got cnt=%0d want 2", count);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    checks++;
    if ({valid_out, count, ready_out, ctrl_out, addr_out, data_out, raw_ctrl} !==
        {1'b0, 2'd0, 1'b1, 3'b000, 3'd0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b cnt=%0d rdy=%b ctrl=%b a=%0d d=%h raw=%b want all zero, rdy=1",
               valid_out, count, ready_out, ctrl_out, addr_out, data_out, raw_ctrl);
    end
    idle(1'b1);
  endtask

  task automatic test_back_to_back_random();
    logic acc;
    logic pend_v;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    logic [CTRL_W-1:0] pc;
    logic fl;
    pend_v = 1'b0; pa = '0; pd = '0; pc = '0;
    for (int i = 0; i < 300; i++) begin
      // Upstream holds an offered entry until it is taken (or squashed by a flush).
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pa = ADDR_W'($urandom_range(0, 7));
        pd = DATA_W'($urandom_range(0, 16'hFFFF));
        pc = CTRL_W'($urandom_range(0, 7));
      end
      fl = ($urandom_range(0, 24) == 0);
      drive(pend_v, pa, pd, pc, $urandom_range(0, 2) != 0, fl, 1'b1, acc);
      if (acc || fl) pend_v = 1'b0;
      checks++;
      if ({valid_out, count, ready_out} !== exp_status()) begin
        errors++;
        $display("FAIL rand_status %0d: got %b want %b", i, {valid_out, count, ready_out}, exp_status());
      end
      if (exp_q.size() > 0) begin
        checks++;
        if ({addr_out, data_out, ctrl_out} !== exp_q[0] || raw_ctrl !== exp_q[0][CTRL_W-1:0]) begin
          errors++;
          $display("FAIL rand_head %0d: got %h raw_ctrl=%b want %h", i, {addr_out, data_out, ctrl_out},
                   raw_ctrl, exp_q[0]);
        end
      end else begin
        checks++;
        if (ctrl_out !== 3'b000) begin
          errors++;
          $display("FAIL rand_bubble %0d: got ctrl=%b want 000", i, ctrl_out);
        end
      end
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    @(negedge CLK);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble_mask();
    test_reset_mid();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline register between decode and execute/writeback stages. It replaces the fixed, always-loading stage registers with a 2-entry skid buffer and a valid/ready handshake. It carries a write address, a generic data payload and a control-bit vector, and supports synchronous flush for branch/PC-load squash. Invalid slots present all-zero control bits, so bubbles never write the register file or load the PC.

Parameters:
ADDR_W, 3, width of write-address field
DATA_W, 16, width of data payload (0 not allowed; min 1)
CTRL_W, 3, width of control vector (bit0 ADR_MUX, bit1 write, bit2 PC_load by default)
MASK_CTRL, 1, 1 = force CTRL_OUT to zero when VALID_OUT=0; 0 = pass stale control bits

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  synchronous active-low reset
FLUSH  in  1  squash all held entries this edge
VALID_IN  in  1  upstream entry valid
READY_OUT  out  1  stage can accept an entry this cycle
writeAd_IN  in  ADDR_W  write address from decode
DATA_IN  in  DATA_W  payload from decode
CTRL_IN  in  CTRL_W  control bits from decode
VALID_OUT  out  1  head entry valid
READY_IN  in  1  downstream accepts head this cycle
writeAd_OUT  out  ADDR_W  head write address
DATA_OUT  out  DATA_W  head payload
CTRL_OUT  out  CTRL_W  head control bits (masked per MASK_CTRL)
COUNT  out  2  occupancy 0..2

Behaviour:
- Clocking: one clock (CLK). Reset is synchronous and active-low (RST_N). Both are fixed.
- Reset (RST_N=0 at edge): both slots invalid, all data/addr/ctrl regs 0. Resulting outputs: VALID_OUT=0, COUNT=0, READY_OUT=1, data outputs 0. Reset overrides FLUSH and all handshakes.
- Storage: main slot (drives outputs) plus skid slot; each has a valid bit.
- Handshake signals:
  - push = VALID_IN & READY_OUT.
  - pop = VALID_OUT & READY_IN.
  - READY_OUT = !skid_valid. It is a pure function of registered state, with no combinational path from READY_IN.
- State machine, encoded from valid bits:
  - EMPTY(0):
    - push -> ONE; main <= input.
    - otherwise stay.
  - ONE(1):
    - push & pop -> ONE; main <= input.
    - push & !pop -> TWO; skid <= input.
    - !push & pop -> EMPTY.
    - idle -> stay.
  - TWO(2):
    - pop -> ONE; main <= skid, skid invalid.
    - no pop -> stay.
    - push is impossible because READY_OUT=0.
- Latency: 1 cycle from push to VALID_OUT when EMPTY. Throughput 1 entry/cycle when READY_IN stays high.
- Ordering: strict FIFO; the skid entry always follows the main entry.
- FLUSH=1 at edge:
  - both valid bits cleared; COUNT=0 next cycle.
  - a simultaneous push is discarded, and so is a simultaneous pop (the downstream must ignore it; FLUSH dominates).
  - payload regs need not clear.
- CTRL_OUT:
  - MASK_CTRL=1 -> CTRL_OUT = VALID_OUT ? ctrl_main : 0.
  - MASK_CTRL=0 -> raw ctrl_main.
- writeAd_OUT and DATA_OUT always present the main slot contents, valid or not.
- COUNT = main_valid + skid_valid. The value 3 is unreachable.
- Upstream rule: VALID_IN and its data must stay stable while VALID_IN=1 and READY_OUT=0. The block does not check this.

Decomposition:
- Shared package pipe_stage_pkg holds:
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
  - control index constants CTRL_ADRMUX=0, CTRL_WRITE=1, CTRL_PCLOAD=2.
- One sub-module, pipe_slot_reg: a load-enabled register holding {valid, writeAd, data, ctrl} with synchronous active-low reset and a clear-valid input. It is instantiated twice (main, skid).

Test Plan:
- Reset then idle: hold RST_N=0 for 2 cycles with VALID_IN=1, CTRL_IN=3'b111 -> VALID_OUT=0, COUNT=0, READY_OUT=1, CTRL_OUT=0 throughout.
- Streaming: READY_IN=1; push addr 1,2,3 with DATA 0x0011,0x0022,0x0033 on consecutive cycles -> VALID_OUT=1 from cycle+1, the same values appear in order one per cycle, COUNT never exceeds 1.
- Backpressure: READY_IN=0; push addr 5 then addr 6 -> COUNT=2, READY_OUT=0. Raise READY_IN -> output addr 5 then addr 6 on successive cycles, and READY_OUT=1 the cycle after the first pop.
- Flush with push: COUNT=2, then FLUSH=1 together with VALID_IN=1 (addr 7) -> next cycle VALID_OUT=0, COUNT=0, and addr 7 never appears.
- Bubble masking: MASK_CTRL=1; push CTRL_IN=3'b110, pop it, then go idle -> CTRL_OUT=3'b110 while valid, 3'b000 afterwards. Repeat with MASK_CTRL=0 -> CTRL_OUT stays 3'b110.
- Reset mid-operation: COUNT=2, then RST_N=0 with READY_IN=1 and FLUSH=0 -> next cycle COUNT=0, VALID_OUT=0, all outputs 0.
